can_error_frame_tx: RTL and testbench
=====================================

CAN_ERROR_FRAME_TX -- requirements
Module: can_error_frame_tx

Interface
REQ-001 SHALL: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL: sample_point  input  1  one-cycle strobe per bit time; all bit-level state changes only on it.
REQ-004 SHALL: rx_bit  input  1  sampled bus level (1 = recessive).
REQ-005 SHALL: bit_error, stuff_error, crc_error, form_error, ack_error  input  1 each  level flags from error detection.
REQ-006 SHALL: in_ack_delimiter  input  1  high during the ACK delimiter bit.
REQ-007 SHALL: error_passive, bus_off  input  1 each  fault-confinement state.
REQ-008 SHALL: tx_bit  output  1  bus drive; 1 when idle.
REQ-009 SHALL: err_frame_active  output  1  high from flag start through last delimiter bit.
REQ-010 SHALL: sending_error_flag_passive  output  1  high while a passive flag is sent.
REQ-011 SHALL: err_type  output  5  latched {bit,stuff,crc,form,ack} at trigger.
REQ-012 SHALL: dom_after_flag, flag_bit_error, excess_dom, err_frame_done  output  1 each  one-cycle pulses.

Function
REQ-013 SHALL: states IDLE, PEND_CRC, FLAG, WAIT_REC, DELIM.
REQ-014 SHALL: IDLE -> FLAG on any sampled non-CRC error; err_type latched that cycle; flag's first bit driven from the next sample_point.
REQ-015 SHALL: crc_error alone -> PEND_CRC; -> FLAG at the sample_point ending in_ack_delimiter; a non-CRC error in PEND_CRC -> FLAG immediately, OR-ing into err_type.
REQ-016 SHALL: active flag (error_passive=0 at trigger) drive tx_bit=0 for 6 bits; rx_bit=1 in any flag bit -> pulse flag_bit_error, restart 6-bit count.
REQ-017 SHALL: passive flag drive tx_bit=1; complete after 6 consecutive equal-polarity sampled bits; polarity change resets count to 1.
REQ-018 SHALL: FLAG -> WAIT_REC after the 6th bit; drive 1; stay until rx_bit=1; pulse dom_after_flag if first WAIT_REC bit is 0.
REQ-019 SHALL: WAIT_REC -> DELIM on the first recessive bit, counted as delimiter bit 1 of 8.
REQ-020 SHALL: DELIM drive 1; rx_bit=0 before bit 8 -> FLAG (new flag, err_type gets form bit set); after bit 8 pulse err_frame_done and -> IDLE.
REQ-021 SHALL: error inputs are ignored outside IDLE/PEND_CRC except per REQ-016/020.
REQ-022 SHALL: bus_off=1 forces IDLE, tx_bit=1, all pulses 0 the next cycle, overriding all other events.
REQ-023 SHALL: flag mode is fixed at trigger; an error_passive change mid-frame takes effect at the next frame.
REQ-024 SHALL: bit counters are 4 bits; dominant-run counter saturates at 15 and never wraps.

Reset
REQ-025 SHALL: on rst: state IDLE, tx_bit=1, err_frame_active=0, sending_error_flag_passive=0, err_type=0, all pulses 0, all counters 0.
REQ-026 SHALL: rst mid-frame abort immediately with no err_frame_done pulse.

Configuration
REQ-027 SHALL: macro CAN_ERR_FRAME_EXCESS_DOM_EN defined -> in WAIT_REC, excess_dom pulses at 14th consecutive dominant bit after the flag, then every further 8 dominant bits.
REQ-028 SHALL: macro undefined -> excess_dom tied 0, run counter not synthesized; port kept.

Structure
REQ-029 SHALL: package can_err_pkg holds the state enum and constants ERR_FLAG_LEN=6, ERR_DELIM_LEN=8, EXCESS_DOM_FIRST=14, EXCESS_DOM_NEXT=8.
REQ-030 SHALL: the dominant-run counter is sub-module can_err_dom_monitor, instantiated only under the macro.

Verification
REQ-031 SHALL: stuff_error at bit N, error_passive=0 -> tx_bit=0 for bits N+1..N+6; bus recessive -> 8 recessive bits, err_frame_done on bit N+14; err_type=5'b01000.
REQ-032 SHALL: crc_error then ACK delimiter -> no flag until the bit after the delimiter; err_type=5'b00100.
REQ-033 SHALL: passive flag; rx pattern 0,0,1,1,1,1,1,1 -> flag completes after 8th bit; sending_error_flag_passive high throughout.
REQ-034 SHALL: active flag with rx_bit=1 on flag bit 3 -> flag_bit_error pulse, 6 further dominant bits.
REQ-035 SHALL: macro on, 22 dominant bits after flag -> dom_after_flag on bit 1, excess_dom on bits 14 and 22.
REQ-036 SHALL: bus_off or rst asserted during DELIM bit 4 -> IDLE and tx_bit=1 next cycle, no err_frame_done.

Source files
------------

// File: rtl/can_error_frame_tx_pkg.sv
// Shared types and constants for the CAN error frame transmitter.
// Optional feature macro: CAN_ERR_FRAME_EXCESS_DOM_EN (dominant-run monitor).
package can_err_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PEND_CRC = 3'd1,
    ST_FLAG     = 3'd2,
    ST_WAIT_REC = 3'd3,
    ST_DELIM    = 3'd4
  } err_state_e;

  localparam logic [3:0] ERR_FLAG_LEN     = 4'd6;
  localparam logic [3:0] ERR_DELIM_LEN    = 4'd8;
  localparam logic [3:0] EXCESS_DOM_FIRST = 4'd14;
  localparam logic [3:0] EXCESS_DOM_NEXT  = 4'd8;

  // err_type bit order is {bit, stuff, crc, form, ack}
  localparam logic [4:0] ERR_FORM_MASK = 5'b00010;

  // Any error other than CRC triggers a flag immediately.
  function automatic logic non_crc_err(input logic [4:0] e);
    return e[4] | e[3] | e[1] | e[0];
  endfunction

endpackage

// File: rtl/can_error_frame_tx_if.sv
// Bus/status bundle between the CAN protocol core and the error frame transmitter.
interface can_error_frame_tx_if;
  logic       sample_point;
  logic       rx_bit;
  logic       bit_error;
  logic       stuff_error;
  logic       crc_error;
  logic       form_error;
  logic       ack_error;
  logic       in_ack_delimiter;
  logic       error_passive;
  logic       bus_off;
  logic       tx_bit;
  logic       err_frame_active;
  logic       sending_error_flag_passive;
  logic [4:0] err_type;
  logic       dom_after_flag;
  logic       flag_bit_error;
  logic       excess_dom;
  logic       err_frame_done;

  // Protocol core side
  modport master (
    output sample_point, rx_bit, bit_error, stuff_error, crc_error, form_error,
           ack_error, in_ack_delimiter, error_passive, bus_off,
    input  tx_bit, err_frame_active, sending_error_flag_passive, err_type,
           dom_after_flag, flag_bit_error, excess_dom, err_frame_done
  );

  // Error frame transmitter side
  modport slave (
    input  sample_point, rx_bit, bit_error, stuff_error, crc_error, form_error,
           ack_error, in_ack_delimiter, error_passive, bus_off,
    output tx_bit, err_frame_active, sending_error_flag_passive, err_type,
           dom_after_flag, flag_bit_error, excess_dom, err_frame_done
  );
endinterface

// File: rtl/can_error_frame_tx_dom_monitor.sv
// Counts consecutive dominant bits while waiting for recessive after a flag and
// strobes on the 14th, then every further 8th dominant bit.
module can_err_dom_monitor
  import can_err_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sample_point,
  input  logic rx_bit,
  output logic hit
);

  logic [3:0] run_cnt;  // saturates at 15
  logic [2:0] ph;       // position inside each 8-bit repeat window past the first hit

  assign hit = en & sample_point & ~rx_bit &
               ((run_cnt == EXCESS_DOM_FIRST - 4'd1) |
                ((run_cnt >= EXCESS_DOM_FIRST) & (ph == 3'(EXCESS_DOM_NEXT - 4'd1))));

  // Run and repeat-phase counters; cleared whenever the monitor is not armed.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      run_cnt <= '0;
      ph      <= '0;
    end else if (sample_point) begin
      if (!rx_bit) begin
        if (run_cnt != 4'hF) run_cnt <= run_cnt + 4'd1;
        if (run_cnt >= EXCESS_DOM_FIRST) ph <= ph + 3'd1;
        else                             ph <= '0;
      end else begin
        run_cnt <= '0;
        ph      <= '0;
      end
    end
  end

endmodule

// File: rtl/can_error_frame_tx.sv
// CAN error frame transmitter: error flag (active/passive), wait for recessive,
// 8-bit delimiter. Optional dominant-run monitor under CAN_ERR_FRAME_EXCESS_DOM_EN.
module can_error_frame_tx
  import can_err_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  can_error_frame_tx_if.slave bus
);

  err_state_e state;
  logic       passive_mode;  // flag mode frozen at trigger
  logic       first_wait;    // next WAIT_REC bit is the first after the flag
  logic       last_pol;      // previous sampled level inside a passive flag
  logic [3:0] flag_cnt;
  logic [3:0] delim_cnt;
  logic [3:0] pas_next;
  logic [4:0] err_type_q;
  logic [4:0] err_vec;
  logic       dom_q, fbe_q, done_q;

  assign err_vec  = {bus.bit_error, bus.stuff_error, bus.crc_error, bus.form_error, bus.ack_error};
  // Passive flag: length of the current equal-polarity run including this bit
  assign pas_next = (flag_cnt != 4'd0 && bus.rx_bit == last_pol) ? flag_cnt + 4'd1 : 4'd1;

  // Main frame sequencer; bus_off behaves like reset but keeps the error diagnosis.
  always_ff @(posedge clk) begin
    if (rst || bus.bus_off) begin
      state        <= ST_IDLE;
      passive_mode <= 1'b0;
      first_wait   <= 1'b0;
      last_pol     <= 1'b0;
      flag_cnt     <= '0;
      delim_cnt    <= '0;
      dom_q        <= 1'b0;
      fbe_q        <= 1'b0;
      done_q       <= 1'b0;
      if (rst) err_type_q <= '0;
    end else begin
      dom_q  <= 1'b0;
      fbe_q  <= 1'b0;
      done_q <= 1'b0;
      if (bus.sample_point) begin
        case (state)
          ST_IDLE: begin
            if (non_crc_err(err_vec)) begin
              state        <= ST_FLAG;
              err_type_q   <= err_vec;
              passive_mode <= bus.error_passive;
              flag_cnt     <= '0;
              last_pol     <= 1'b0;
            end else if (bus.crc_error) begin
              state      <= ST_PEND_CRC;
              err_type_q <= err_vec;
            end
          end
          ST_PEND_CRC: begin
            if (non_crc_err(err_vec) || bus.in_ack_delimiter) begin
              state        <= ST_FLAG;
              err_type_q   <= err_type_q | err_vec;
              passive_mode <= bus.error_passive;
              flag_cnt     <= '0;
              last_pol     <= 1'b0;
            end
          end
          ST_FLAG: begin
            if (!passive_mode) begin
              if (bus.rx_bit) begin
                fbe_q    <= 1'b1;
                flag_cnt <= '0;
              end else if (flag_cnt == ERR_FLAG_LEN - 4'd1) begin
                state      <= ST_WAIT_REC;
                first_wait <= 1'b1;
                flag_cnt   <= '0;
              end else begin
                flag_cnt <= flag_cnt + 4'd1;
              end
            end else begin
              last_pol <= bus.rx_bit;
              if (pas_next == ERR_FLAG_LEN) begin
                state      <= ST_WAIT_REC;
                first_wait <= 1'b1;
                flag_cnt   <= '0;
              end else begin
                flag_cnt <= pas_next;
              end
            end
          end
          ST_WAIT_REC: begin
            first_wait <= 1'b0;
            if (bus.rx_bit) begin
              state     <= ST_DELIM;
              delim_cnt <= 4'd1;
            end else if (first_wait) begin
              dom_q <= 1'b1;
            end
          end
          ST_DELIM: begin
            if (!bus.rx_bit) begin
              // Dominant inside the delimiter is a form error: start over.
              state        <= ST_FLAG;
              err_type_q   <= err_type_q | ERR_FORM_MASK;
              passive_mode <= bus.error_passive;
              flag_cnt     <= '0;
              last_pol     <= 1'b0;
              delim_cnt    <= '0;
            end else if (delim_cnt == ERR_DELIM_LEN - 4'd1) begin
              state     <= ST_IDLE;
              done_q    <= 1'b1;
              delim_cnt <= '0;
            end else begin
              delim_cnt <= delim_cnt + 4'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef CAN_ERR_FRAME_EXCESS_DOM_EN
  logic excess_hit, excess_q;

  can_err_dom_monitor u_dom_mon (
    .clk          (clk),
    .rst          (rst),
    .en           ((state == ST_WAIT_REC) && !bus.bus_off),
    .sample_point (bus.sample_point),
    .rx_bit       (bus.rx_bit),
    .hit          (excess_hit)
  );

  // Register the monitor strobe so it lines up with the other pulses.
  always_ff @(posedge clk) begin
    if (rst || bus.bus_off) excess_q <= 1'b0;
    else                    excess_q <= excess_hit;
  end

  assign bus.excess_dom = excess_q;
`else
  assign bus.excess_dom = 1'b0;
`endif

  assign bus.tx_bit                     = !((state == ST_FLAG) && !passive_mode);
  assign bus.err_frame_active           = (state == ST_FLAG) || (state == ST_WAIT_REC) ||
                                          (state == ST_DELIM);
  assign bus.sending_error_flag_passive = (state == ST_FLAG) && passive_mode;
  assign bus.err_type                   = err_type_q;
  assign bus.dom_after_flag             = dom_q;
  assign bus.flag_bit_error             = fbe_q;
  assign bus.err_frame_done             = done_q;

endmodule

// File: tb/tb_can_error_frame_tx.sv
// Directed bench for can_error_frame_tx: per-bit vector table plus hand sequences
// for bus_off/reset aborts and long dominant runs.
module tb_can_error_frame_tx;
  import can_err_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  can_error_frame_tx_if bus_if ();

  can_error_frame_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

`ifdef CAN_ERR_FRAME_EXCESS_DOM_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  // pre = {tx_bit, err_frame_active, sending_error_flag_passive} at the sample point
  // pul = {dom_after_flag, flag_bit_error, excess_dom, err_frame_done} right after it
  typedef struct {
    logic       rx;
    logic [4:0] err;
    logic       ackd;
    logic       ep;
    logic [2:0] pre;
    logic [3:0] pul;
    logic [4:0] et;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rx, input logic [4:0] err, input logic ackd, input logic ep,
                     input logic [2:0] pre, input logic [3:0] pul, input logic [4:0] et);
    vec_t v;
    v.rx = rx; v.err = err; v.ackd = ackd; v.ep = ep; v.pre = pre; v.pul = pul; v.et = et;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // One bit time: 4 clocks, sample_point in the first.
  task automatic run_bit(input logic rx, input logic [4:0] err, input logic ackd, input logic ep,
                         output logic [2:0] pre, output logic [3:0] pul, output logic [4:0] et);
    @(negedge clk);
    bus_if.rx_bit = rx;
    {bus_if.bit_error, bus_if.stuff_error, bus_if.crc_error, bus_if.form_error,
     bus_if.ack_error} = err;
    bus_if.in_ack_delimiter = ackd;
    bus_if.error_passive = ep;
    bus_if.sample_point = 1'b1;
    pre = {bus_if.tx_bit, bus_if.err_frame_active, bus_if.sending_error_flag_passive};
    @(negedge clk);
    bus_if.sample_point = 1'b0;
    pul = {bus_if.dom_after_flag, bus_if.flag_bit_error, bus_if.excess_dom, bus_if.err_frame_done};
    et = bus_if.err_type;
    {bus_if.bit_error, bus_if.stuff_error, bus_if.crc_error, bus_if.form_error,
     bus_if.ack_error} = 5'b0;
    bus_if.in_ack_delimiter = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [2:0] pre;
  logic [3:0] pul;
  logic [4:0] et;

  initial begin
    logic [7:0] pat;
    bus_if.sample_point = 0; bus_if.rx_bit = 1; bus_if.bit_error = 0; bus_if.stuff_error = 0;
    bus_if.crc_error = 0; bus_if.form_error = 0; bus_if.ack_error = 0;
    bus_if.in_ack_delimiter = 0; bus_if.error_passive = 0; bus_if.bus_off = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {bus_if.tx_bit, bus_if.err_frame_active, bus_if.sending_error_flag_passive,
                        bus_if.err_type, bus_if.dom_after_flag, bus_if.flag_bit_error,
                        bus_if.excess_dom, bus_if.err_frame_done}, {3'b100, 5'b0, 4'b0});

    // A: active flag after stuff error, recessive bus, error input ignored mid-flag
    add(1, 5'b00000, 0, 0, 3'b100, 4'b0000, 5'b00000);
    add(1, 5'b01000, 0, 0, 3'b100, 4'b0000, 5'b01000);
    for (int i = 0; i < 6; i++) add(0, (i == 1) ? 5'b10000 : 5'b0, 0, 0, 3'b010, 4'b0000, 5'b01000);
    add(1, 5'b0, 0, 0, 3'b110, 4'b0000, 5'b01000);
    for (int i = 0; i < 6; i++) add(1, 5'b0, 0, 0, 3'b110, 4'b0000, 5'b01000);
    add(1, 5'b0, 0, 0, 3'b110, 4'b0001, 5'b01000);
    add(1, 5'b0, 0, 0, 3'b100, 4'b0000, 5'b01000);
    // B: CRC error waits for the ACK delimiter; dominant first bit after flag
    add(1, 5'b00100, 0, 0, 3'b100, 4'b0000, 5'b00100);
    add(0, 5'b00100, 0, 0, 3'b100, 4'b0000, 5'b00100);
    add(1, 5'b00000, 1, 0, 3'b100, 4'b0000, 5'b00100);
    for (int i = 0; i < 6; i++) add(0, 5'b0, 0, 0, 3'b010, 4'b0000, 5'b00100);
    add(0, 5'b0, 0, 0, 3'b110, 4'b1000, 5'b00100);
    add(1, 5'b0, 0, 0, 3'b110, 4'b0000, 5'b00100);
    for (int i = 0; i < 6; i++) add(1, 5'b0, 0, 0, 3'b110, 4'b0000, 5'b00100);
    add(1, 5'b0, 0, 0, 3'b110, 4'b0001, 5'b00100);
    add(1, 5'b0, 0, 0, 3'b100, 4'b0000, 5'b00100);
    // C: CRC pending, form error forces passive flag at once; mode held when ep drops
    add(1, 5'b00100, 0, 1, 3'b100, 4'b0000, 5'b00100);
    add(1, 5'b00010, 0, 1, 3'b100, 4'b0000, 5'b00110);
    pat = 8'b00111111;
    for (int i = 0; i < 8; i++) add(pat[7-i], 5'b0, 0, 0, 3'b111, 4'b0000, 5'b00110);
    add(1, 5'b0, 0, 0, 3'b110, 4'b0000, 5'b00110);
    for (int i = 0; i < 6; i++) add(1, 5'b0, 0, 0, 3'b110, 4'b0000, 5'b00110);
    add(1, 5'b0, 0, 0, 3'b110, 4'b0001, 5'b00110);
    add(1, 5'b0, 0, 0, 3'b100, 4'b0000, 5'b00110);
    // D: flag bit error on bit 3, then dominant delimiter bit 3 restarts the flag
    add(1, 5'b10000, 0, 0, 3'b100, 4'b0000, 5'b10000);
    add(0, 5'b0, 0, 0, 3'b010, 4'b0000, 5'b10000);
    add(0, 5'b0, 0, 0, 3'b010, 4'b0000, 5'b10000);
    add(1, 5'b0, 0, 0, 3'b010, 4'b0100, 5'b10000);
    for (int i = 0; i < 6; i++) add(0, 5'b0, 0, 0, 3'b010, 4'b0000, 5'b10000);
    add(1, 5'b0, 0, 0, 3'b110, 4'b0000, 5'b10000);
    add(1, 5'b0, 0, 0, 3'b110, 4'b0000, 5'b10000);
    add(0, 5'b0, 0, 0, 3'b110, 4'b0000, 5'b10010);
    for (int i = 0; i < 6; i++) add(0, 5'b0, 0, 0, 3'b010, 4'b0000, 5'b10010);
    add(1, 5'b0, 0, 0, 3'b110, 4'b0000, 5'b10010);
    for (int i = 0; i < 6; i++) add(1, 5'b0, 0, 0, 3'b110, 4'b0000, 5'b10010);
    add(1, 5'b0, 0, 0, 3'b110, 4'b0001, 5'b10010);
    add(1, 5'b0, 0, 0, 3'b100, 4'b0000, 5'b10010);

    foreach (tbl[i]) begin
      run_bit(tbl[i].rx, tbl[i].err, tbl[i].ackd, tbl[i].ep, pre, pul, et);
      chk($sformatf("vec%0d_tx_act_pas", i), 32'(pre), 32'(tbl[i].pre));
      chk($sformatf("vec%0d_pulses", i), 32'(pul), 32'(tbl[i].pul));
      chk($sformatf("vec%0d_err_type", i), 32'(et), 32'(tbl[i].et));
    end

    // bus_off and rst during delimiter bit 4: abort, no done pulse
    for (int k = 0; k < 2; k++) begin
      run_bit(1, 5'b01000, 0, 0, pre, pul, et);
      for (int i = 0; i < 6; i++) run_bit(0, 5'b0, 0, 0, pre, pul, et);
      for (int i = 0; i < 3; i++) run_bit(1, 5'b0, 0, 0, pre, pul, et);
      @(negedge clk);
      bus_if.rx_bit = 1'b1;
      bus_if.sample_point = 1'b1;
      if (k == 0) bus_if.bus_off = 1'b1; else rst = 1'b1;
      @(negedge clk);
      bus_if.sample_point = 1'b0;
      chk($sformatf("abort%0d_next_cycle", k),
          {bus_if.tx_bit, bus_if.err_frame_active, bus_if.sending_error_flag_passive,
           bus_if.dom_after_flag, bus_if.flag_bit_error, bus_if.excess_dom, bus_if.err_frame_done},
          7'b1000000);
      bus_if.bus_off = 1'b0;
      rst = 1'b0;
      if (k == 1) chk("abort_rst_err_type", 32'(bus_if.err_type), 32'd0);
      for (int i = 0; i < 6; i++) begin
        run_bit(1, 5'b0, 0, 0, pre, pul, et);
        chk($sformatf("abort%0d_quiet_bit%0d", k, i), {pre[1], pul[0]}, 2'b00);
      end
    end

    // Long dominant run after an active flag
    run_bit(1, 5'b10000, 0, 0, pre, pul, et);
    for (int i = 0; i < 6; i++) run_bit(0, 5'b0, 0, 0, pre, pul, et);
    for (int b = 1; b <= 22; b++) begin
      run_bit(0, 5'b0, 0, 0, pre, pul, et);
      chk($sformatf("domrun_bit%0d", b), {pre, pul},
          {3'b110, (b == 1), 1'b0, EXC_EN && (b == 14 || b == 22), 1'b0});
    end
    for (int i = 0; i < 8; i++) begin
      run_bit(1, 5'b0, 0, 0, pre, pul, et);
      chk($sformatf("domrun_delim%0d", i + 1), 32'(pul), (i == 7) ? 32'd1 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
